// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer blocks: scheduler state,
// default layer geometry and the index/address widths used across blocks.
package cnn_pkg;

  localparam int DEF_IMG_W           = 28;
  localparam int DEF_IMG_H           = 28;
  localparam int DEF_K               = 5;
  localparam int DEF_NUM_KERNELS     = 6;
  localparam int DEF_MAX_OUTSTANDING = 8;

  localparam int OW         = DEF_IMG_W - DEF_K + 1;
  localparam int OH         = DEF_IMG_H - DEF_K + 1;
  localparam int OUT_PIXELS = OW * OH;

  localparam int KIDX_W = 5;
  localparam int ADDR_W = 10;
  localparam int POS_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } sched_state_t;

endpackage

// File: rtl/win_pos_counter.sv
// Row-major (row, col) position counter over a ROWS x COLS grid with a
// last-position flag; wraps back to (0,0) when advanced from the last position.
module win_pos_counter #(
  parameter int COLS = 24,
  parameter int ROWS = 24,
  parameter int W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  localparam logic [W-1:0] COL_MAX = W'(COLS - 1);
  localparam logic [W-1:0] ROW_MAX = W'(ROWS - 1);

  logic [W-1:0] row_reg;
  logic [W-1:0] col_reg;

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clr) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (adv) begin
      if (last) begin
        row_reg <= '0;
        col_reg <= '0;
      end else if (col_reg == COL_MAX) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer sequencer: loads each kernel, sweeps all window positions
// with a bounded number in flight, and turns returned results into output writes.
module conv_layer_sched
  import cnn_pkg::*;
#(
  parameter int IMG_W           = DEF_IMG_W,
  parameter int IMG_H           = DEF_IMG_H,
  parameter int K               = DEF_K,
  parameter int NUM_KERNELS     = DEF_NUM_KERNELS,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        kload_en,
  output logic [4:0]  kload_num,
  input  logic        kload_ok,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [4:0]  win_row,
  output logic [4:0]  win_col,
  input  logic        res_valid,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [4:0]  wr_kernel,
  output logic        err
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int N_PIX = OUT_W * OUT_H;
  localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OST_W-1:0]  OST_MAX  = OST_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [KIDX_W-1:0] LAST_K   = KIDX_W'(NUM_KERNELS - 1);

  generate
    if (N_PIX > 1024 || NUM_KERNELS > 32 || NUM_KERNELS < 1) begin : g_bad_geometry
      $error("conv_layer_sched: output map or kernel count out of range");
    end
  endgenerate

  sched_state_t      state_reg, state_next;
  logic [KIDX_W-1:0] kernel_reg, kernel_next;
  logic [ADDR_W-1:0] res_cnt_reg;
  logic [OST_W-1:0]  ost_reg;
  logic              err_reg;

  logic start_ok, xfer, last_pos, drain_done;

  assign start_ok   = (state_reg == ST_IDLE) && start;
  assign win_valid  = (state_reg == ST_RUN) && (ost_reg < OST_MAX);
  assign xfer       = win_valid && win_ready;
  // Results only count against windows actually in flight.
  assign wr_en      = res_valid && (ost_reg != '0) &&
                      ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
  // Results return in order, so the last pixel's write closes the kernel.
  assign drain_done = (state_reg == ST_DRAIN) && wr_en && (res_cnt_reg == LAST_PIX);

  assign kload_num = kernel_reg;
  assign wr_addr   = res_cnt_reg;
  assign wr_kernel = kernel_reg;
  assign err       = err_reg;

  win_pos_counter #(
    .COLS (OUT_W),
    .ROWS (OUT_H),
    .W    (POS_W)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .adv  (xfer),
    .row  (win_row),
    .col  (win_col),
    .last (last_pos)
  );

  always_comb begin
    state_next  = state_reg;
    kernel_next = kernel_reg;
    busy        = 1'b0;
    done        = 1'b0;
    kload_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_LOAD;
          kernel_next = '0;
        end
      end
      ST_LOAD: begin
        busy     = 1'b1;
        kload_en = 1'b1;
        if (kload_ok) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (xfer && last_pos) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_done) begin
          if (kernel_reg == LAST_K) begin
            state_next = ST_FIN;
          end else begin
            kernel_next = kernel_reg + 1'b1;
            state_next  = ST_LOAD;
          end
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      kernel_reg  <= '0;
      res_cnt_reg <= '0;
      ost_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      kernel_reg <= kernel_next;

      case ({xfer, wr_en})
        2'b10:   ost_reg <= ost_reg + 1'b1;
        2'b01:   ost_reg <= ost_reg - 1'b1;
        default: ost_reg <= ost_reg;
      endcase

      if (drain_done)  res_cnt_reg <= '0;
      else if (wr_en)  res_cnt_reg <= res_cnt_reg + 1'b1;

      if (start_ok)                          err_reg <= 1'b0;
      else if (res_valid && ost_reg == '0)   err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: table of layer scenarios driven
// against a count-based reference model, plus hand-written error/reset cases.
module tb_conv_layer_sched;

  localparam int NK   = 2;
  localparam int OWB  = 28 - 5 + 1;
  localparam int NPIX = OWB * (28 - 5 + 1);
  localparam int MAXO = 8;

  logic       clk, rst, start;
  logic       busy, done, kload_en, kload_ok;
  logic [4:0] kload_num, win_row, win_col, wr_kernel;
  logic       win_valid, win_ready, res_valid, wr_en, err;
  logic [9:0] wr_addr;

  conv_layer_sched #(.NUM_KERNELS(NK)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .kload_en(kload_en), .kload_num(kload_num), .kload_ok(kload_ok),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_col(win_col), .res_valid(res_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_kernel(wr_kernel), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".kload_en"}, kload_en, 0);
    chk({tag, ".kload_num"}, kload_num, 0);
    chk({tag, ".win_valid"}, win_valid, 0);
    chk({tag, ".win_row"}, win_row, 0);
    chk({tag, ".win_col"}, win_col, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_kernel"}, wr_kernel, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready
  typedef struct {
    int mode; int lat_lo; int lat_hi; int kdelay;
    int poke_at; int abort_at; int exp_wr; int exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic run_layer(input vec_t v, input int idx);
    int  kern = 0, tr_k = 0, wr_k = 0, wr_total = 0, kl_cnt = 0;
    int  done_cnt = 0, last_res = 0, t = 0, cyc = 0;
    bit  load_pend = 0, running = 0, done_exp = 0, poked = 0, finished = 0;
    int  resq[$];
    for (cyc = 0; cyc < 30000 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (v.poke_at >= 0 && !poked && kern == 0 && tr_k >= v.poke_at);
      if (start && cyc != 0) poked = 1;
      kload_ok = load_pend && (kl_cnt == v.kdelay);
      case (v.mode)
        0:       win_ready = 1'b1;
        1:       win_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      res_valid = (resq.size() > 0) && (resq[0] <= cyc);
      #1;
      chk("kload_en", kload_en, int'(load_pend));
      if (kload_en) chk("kload_num", kload_num, kern);
      chk("win_valid", win_valid, int'(running && (tr_k - wr_k) < MAXO));
      chk("wr_en", wr_en, int'(res_valid));
      chk("done", done, int'(done_exp));
      chk("busy", busy, int'(cyc > 0 && !done_exp));
      if (cyc > 0) chk("err", err, 0);
      done_cnt += int'(done);
      if (done_exp) finished = 1;
      if (win_valid && win_ready) begin
        chk("win_row", win_row, tr_k / OWB);
        chk("win_col", win_col, tr_k % OWB);
        tr_k++;
        t = cyc + int'($urandom_range(v.lat_lo, v.lat_hi));
        if (t <= last_res) t = last_res + 1;
        resq.push_back(t);
        last_res = t;
        if (tr_k == NPIX) running = 0;
      end
      if (res_valid) void'(resq.pop_front());
      if (wr_en) begin
        chk("wr_addr", wr_addr, wr_k);
        chk("wr_kernel", wr_kernel, kern);
        wr_k++;
        wr_total++;
        if (wr_k == NPIX) begin
          if (kern == NK - 1) done_exp = 1;
          else begin
            kern++; tr_k = 0; wr_k = 0; load_pend = 1;
          end
        end
      end
      if (load_pend && kload_en && cyc > 0) begin
        if (kload_ok) begin
          load_pend = 0; running = 1; kl_cnt = 0;
        end else kl_cnt++;
      end
      if (cyc == 0) load_pend = 1;
      if (v.abort_at >= 0 && tr_k == v.abort_at && !finished) begin
        rst = 1'b1; start = 1'b0; win_ready = 1'b0; res_valid = 1'b0; kload_ok = 1'b0;
        #1;
        check_reset_outputs("abort_in_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort_after_rst");
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          done_cnt += int'(done);
          chk("abort_idle_busy", busy, 0);
        end
        finished = 1;
      end
    end
    start = 1'b0; win_ready = 1'b0; res_valid = 1'b0; kload_ok = 1'b0;
    chk("layer_finished", int'(finished), 1);
    if (v.exp_wr >= 0) chk("total_wr", wr_total, v.exp_wr);
    chk("done_pulses", done_cnt, v.exp_done);
    $display("[TB] vec %0d mode %0d lat %0d..%0d kdelay %0d: %0d writes, %0d done pulses, %0d cycles",
             idx, v.mode, v.lat_lo, v.lat_hi, v.kdelay, wr_total, done_cnt, cyc);
  endtask

  initial begin
    vecs[0] = '{0, 4, 4, 3, -1, -1, NK * NPIX, 1};   // nominal
    vecs[1] = '{1, 4, 4, 1, -1, -1, NK * NPIX, 1};   // backpressure pattern
    vecs[2] = '{0, 20, 20, 2, -1, -1, NK * NPIX, 1}; // outstanding limit / drain boundary
    vecs[3] = '{0, 4, 4, 3, -1, 100, -1, 0};         // reset mid-RUN
    vecs[4] = '{2, 1, 15, 2, 300, -1, NK * NPIX, 1}; // random, start poked while busy
    vecs[5] = '{2, 1, 30, 4, -1, -1, NK * NPIX, 1};  // random, long latency

    rst = 1'b1; start = 1'b0; kload_ok = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Spurious result while idle: no write, sticky error.
    @(negedge clk);
    res_valid = 1'b1;
    #1;
    chk("spurious_wr_en", wr_en, 0);
    $display("[TB] spurious res_valid in IDLE: wr_en=%0d", wr_en);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("spurious_err_set", err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("spurious_err_sticky", err, 1);
    chk("spurious_no_busy", busy, 0);

    // Next start must clear err (checked from the cycle after start).
    for (int i = 0; i < 6; i++) run_layer(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
